uart_echo_fifo: RTL

UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

---
 rtl/uart_echo_pkg.sv | 39 +++
 rtl/uart_echo_fifo_byte_fifo.sv | 50 +++++
 rtl/uart_echo_fifo.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_echo_pkg.sv
// Shared encodings for the UART echo path: TX FSM states, the transmit modes
// and the ASCII constants used by the character formatter.
package uart_echo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_NEXT
  } tx_state_e;

  typedef enum logic [1:0] {
    MODE_ECHO    = 2'b00,
    MODE_UPPER   = 2'b01,
    MODE_HEX     = 2'b10,
    MODE_DISCARD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    PH_HI,
    PH_LO,
    PH_SEP
  } hex_phase_e;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  function automatic logic [7:0] hex_digit(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_0 + {4'd0, nib};
    else             return ASCII_A + {4'd0, nib - 4'd10};
  endfunction

endpackage

// File: rtl/uart_echo_fifo_byte_fifo.sv
// Power-of-two circular FIFO with first-word-fall-through read data.
module byte_fifo #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              not_reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_ok, pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge not_reset) begin
    if (not_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffers received UART bytes and retransmits them as echo, uppercase,
// hex dump or nothing, handshaking with the transmitter via tx_ready.
module uart_echo_fifo
  import uart_echo_pkg::*;
#(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned DEPTH    = 16,
  parameter  logic [7:0]  SEP_CHAR = 8'h20,
  parameter  int unsigned BUSY_TO  = 16,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              not_reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              tx_ready,
  input  logic [1:0]        mode,
  input  logic              clear_ovf,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned TO_W = $clog2(BUSY_TO + 1);

  tx_state_e         state_q;
  mode_e             mode_q;
  hex_phase_e        phase_q;
  logic [DATA_W-1:0] byte_q, tx_data_q, fmt_char;
  logic [TO_W-1:0]   to_cnt_q;
  logic              tx_start_q, busy_q, overflow_q, rx_ready_q;
  logic              rx_edge, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign rx_edge  = rx_ready && !rx_ready_q;
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  byte_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .not_reset  (not_reset),
    .push_i     (rx_edge),
    .push_data_i(rx_data),
    .pop_i      (fifo_pop),
    .pop_data_o (fifo_rdata),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clk or posedge not_reset) begin
    if (not_reset) begin
      rx_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
      if (rx_edge && fifo_full) overflow_q <= 1'b1;
      else if (clear_ovf)       overflow_q <= 1'b0;
    end
  end

  always_comb begin
    fmt_char = byte_q;
    unique case (mode_q)
      MODE_UPPER: begin
        if (byte_q >= DATA_W'(ASCII_LC_A) && byte_q <= DATA_W'(ASCII_LC_Z))
          fmt_char = byte_q - DATA_W'(CASE_OFFSET);
      end
      MODE_HEX: begin
        unique case (phase_q)
          PH_HI:   fmt_char = DATA_W'(hex_digit(byte_q[7:4]));
          PH_LO:   fmt_char = DATA_W'(hex_digit(byte_q[3:0]));
          default: fmt_char = DATA_W'(SEP_CHAR);
        endcase
      end
      default: fmt_char = byte_q;
    endcase
  end

  // busy_q and tx_start_q are updated alongside state_q so they stay registered.
  always_ff @(posedge clk or posedge not_reset) begin
    if (not_reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ECHO;
      phase_q    <= PH_HI;
      byte_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            byte_q  <= fifo_rdata;
            mode_q  <= mode_e'(mode);
            phase_q <= PH_HI;
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (mode_q == MODE_DISCARD) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            tx_data_q <= fmt_char;
            if (tx_ready) begin
              state_q    <= ST_START;
              tx_start_q <= 1'b1;
            end
          end
        end
        ST_START: begin
          to_cnt_q <= '0;
          state_q  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!tx_ready || to_cnt_q == TO_W'(BUSY_TO - 1)) state_q <= ST_WAIT_DONE;
          else to_cnt_q <= to_cnt_q + TO_W'(1);
        end
        ST_WAIT_DONE: begin
          if (tx_ready) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (mode_q == MODE_HEX && phase_q != PH_SEP) begin
            phase_q <= (phase_q == PH_HI) ? PH_LO : PH_SEP;
            state_q <= ST_LOAD;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule
